// File: rtl/sonar_pkg.sv
// Shared sonar types and constants: ping sequencer state encoding,
// default carrier period (also used by pwm instances), small helpers.
package sonar_pkg;

   localparam int unsigned PERIOD_CYCLES = 2500;

   typedef enum logic [2:0] {
      IDLE,
      TX,
      RINGDOWN,
      LISTEN,
      DONE,
      WAIT
   } ping_state_t;

   function automatic int unsigned max3(
      input int unsigned a,
      input int unsigned b,
      input int unsigned c
   );
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/ping_sequencer_if.sv
// Control/status bundle of the ping sequencer.
// master: trigger/range logic side; slave: the sequencer.
// Signals: trigger_in, abort_in, num_pulses_in, echo_in (to sequencer);
// pwm_rst_out, tx_en_out, listen_out, busy_out, done_out,
// tof_out, tof_valid_out (from sequencer).
interface ping_sequencer_if #(
   parameter int unsigned PULSE_W = 8,
   parameter int unsigned TOF_W   = 24
);
   logic               trigger_in;
   logic               abort_in;
   logic [PULSE_W-1:0] num_pulses_in;
   logic               echo_in;
   logic               pwm_rst_out;
   logic               tx_en_out;
   logic               listen_out;
   logic               busy_out;
   logic               done_out;
   logic [TOF_W-1:0]   tof_out;
   logic               tof_valid_out;

   modport master (
      output trigger_in, abort_in, num_pulses_in, echo_in,
      input  pwm_rst_out, tx_en_out, listen_out, busy_out,
      input  done_out, tof_out, tof_valid_out
   );

   modport slave (
      input  trigger_in, abort_in, num_pulses_in, echo_in,
      output pwm_rst_out, tx_en_out, listen_out, busy_out,
      output done_out, tof_out, tof_valid_out
   );
endinterface

// File: rtl/ping_period_ticker.sv
// Carrier period counter: counts 0..PERIOD_CYCLES-1 and wraps while
// clr_in is low; tick_out marks the last cycle of each period.
// Ports: clk_in, rst_in (async, active-high), clr_in, tick_out.
module ping_period_ticker #(
   parameter int unsigned PERIOD_CYCLES = sonar_pkg::PERIOD_CYCLES
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic clr_in,
   output logic tick_out
);
   localparam int unsigned CW =
      (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

   logic [CW-1:0] cnt;

   assign tick_out = !clr_in && (cnt == LAST);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)
         cnt <= '0;
      else if (clr_in || cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end
endmodule

// File: rtl/ping_sequencer.sv
// Ultrasonic ping sequencer: N-period TX burst, ring-down blanking,
// echo listen window with time-of-flight capture of the first echo.
// Ports: clk_in, rst_in (async, active-high), bus (ping_sequencer_if.slave).
// Option: SONAR_AUTO_REPEAT_EN adds a WAIT state and automatic re-ping.
module ping_sequencer #(
   parameter int unsigned PERIOD_CYCLES = sonar_pkg::PERIOD_CYCLES,
   parameter int unsigned PULSE_W       = 8,
   parameter int unsigned BLANK_CYCLES  = 50000,
   parameter int unsigned LISTEN_CYCLES = 2500000,
   parameter int unsigned TOF_W         = 24,
   parameter int unsigned REPEAT_CYCLES = 1000000
) (
   input logic             clk_in,
   input logic             rst_in,
   ping_sequencer_if.slave bus
);
   import sonar_pkg::*;

   localparam int unsigned DUR_MAX =
      max3(BLANK_CYCLES, LISTEN_CYCLES, REPEAT_CYCLES);
   localparam int unsigned DUR_W = $clog2(DUR_MAX + 1);
   localparam logic [DUR_W-1:0] BLANK_LAST  = DUR_W'(BLANK_CYCLES - 1);
   localparam logic [DUR_W-1:0] LISTEN_LAST = DUR_W'(LISTEN_CYCLES - 1);
`ifdef SONAR_AUTO_REPEAT_EN
   localparam logic [DUR_W-1:0] REPEAT_LAST = DUR_W'(REPEAT_CYCLES - 1);
`endif

   ping_state_t        state, state_d;
   logic [DUR_W-1:0]   dur_cnt;
   logic [TOF_W-1:0]   tof_cnt;
   logic [PULSE_W-1:0] n_lat;
   logic [PULSE_W-1:0] pulse_cnt;
   logic               tick;
   logic               in_tx;
   logic               tx_last;
   logic               accept;
   logic               tx_entry;
   logic               capture;

   logic               pwm_rst_q;
   logic               tx_en_q;
   logic               listen_q;
   logic               busy_q;
   logic               done_q;
   logic [TOF_W-1:0]   tof_q;
   logic               tof_valid_q;

   assign in_tx    = (state == TX);
   assign tx_last  = tick && (pulse_cnt == n_lat - PULSE_W'(1));
   // abort priority is already folded into state_d
   assign accept   = (state == IDLE) && (state_d != IDLE);
   assign tx_entry = (state_d == TX) && !in_tx;
   assign capture  = (state == LISTEN) && bus.echo_in &&
                     !tof_valid_q && !bus.abort_in;

   ping_period_ticker #(
      .PERIOD_CYCLES(PERIOD_CYCLES)
   ) u_ticker (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .clr_in  (!in_tx),
      .tick_out(tick)
   );

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:
            if (bus.trigger_in)
               state_d = (bus.num_pulses_in == '0) ? DONE : TX;
         TX:
            if (tx_last) state_d = RINGDOWN;
         RINGDOWN:
            if (dur_cnt == BLANK_LAST) state_d = LISTEN;
         LISTEN:
            if (dur_cnt == LISTEN_LAST) state_d = DONE;
`ifdef SONAR_AUTO_REPEAT_EN
         DONE:
            state_d = (n_lat == '0) ? IDLE : WAIT;
         WAIT:
            if (dur_cnt == REPEAT_LAST) state_d = TX;
`else
         DONE:
            state_d = IDLE;
         WAIT:
            state_d = IDLE;
`endif
         default:
            state_d = IDLE;
      endcase
      if (bus.abort_in) state_d = IDLE;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state       <= IDLE;
         dur_cnt     <= '0;
         tof_cnt     <= '0;
         n_lat       <= '0;
         pulse_cnt   <= '0;
         tof_q       <= '0;
         tof_valid_q <= 1'b0;
         pwm_rst_q   <= 1'b1;
         tx_en_q     <= 1'b0;
         listen_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state   <= state_d;
         dur_cnt <= (state_d != state) ? '0 : dur_cnt + DUR_W'(1);

         // ToF restarts at every burst and saturates
         if (tx_entry)
            tof_cnt <= '0;
         else if (tof_cnt != '1)
            tof_cnt <= tof_cnt + TOF_W'(1);

         if (!in_tx)
            pulse_cnt <= '0;
         else if (tick)
            pulse_cnt <= pulse_cnt + PULSE_W'(1);

         if (accept) n_lat <= bus.num_pulses_in;

         if (accept || tx_entry) begin
            tof_q       <= '0;
            tof_valid_q <= 1'b0;
         end else if (bus.abort_in && state != IDLE) begin
            tof_valid_q <= 1'b0;
         end else if (capture) begin
            tof_q       <= tof_cnt;
            tof_valid_q <= 1'b1;
         end

         pwm_rst_q <= (state_d != TX);
         tx_en_q   <= (state_d == TX);
         listen_q  <= (state_d == LISTEN);
         busy_q    <= (state_d != IDLE);
         done_q    <= (state_d == DONE);
      end
   end

   assign bus.pwm_rst_out   = pwm_rst_q;
   assign bus.tx_en_out     = tx_en_q;
   assign bus.listen_out    = listen_q;
   assign bus.busy_out      = busy_q;
   assign bus.done_out      = done_q;
   assign bus.tof_out       = tof_q;
   assign bus.tof_valid_out = tof_valid_q;
endmodule

// File: tb/tb_ping_sequencer.sv
// Self-checking bench for ping_sequencer: scenario table run against a
// cycle timeline model through a scoreboard queue, plus async reset case.
module tb_ping_sequencer;
   localparam int P  = 10;
   localparam int B  = 20;
   localparam int L  = 100;
   localparam int R  = 10;
   localparam int PW = 8;
   localparam int TW = 24;
`ifdef SONAR_AUTO_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   typedef struct {
      int n;
      int lo;
      int hi;
      int e2;
      int ab;
      int tr2;
      int len;
   } scn_t;

   typedef struct {
      bit tx;
      bit pwm;
      bit lis;
      bit busy;
      bit done;
      bit val;
      int tof;
      bit ctof;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   scn_t tbl[$];
   exp_t sb[$];

   always #5 clk = ~clk;

   ping_sequencer_if #(.PULSE_W(PW), .TOF_W(TW)) bus();

   ping_sequencer #(
      .PERIOD_CYCLES(P),
      .PULSE_W(PW),
      .BLANK_CYCLES(B),
      .LISTEN_CYCLES(L),
      .TOF_W(TW),
      .REPEAT_CYCLES(R)
   ) dut (
      .clk_in(clk),
      .rst_in(rst),
      .bus   (bus)
   );

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   function automatic bit echo_at(input scn_t s, input int c);
      return (s.lo >= 0 && c >= s.lo && c <= s.hi) ||
             (s.e2 >= 0 && c == s.e2);
   endfunction

   function automatic int done_of(input scn_t s);
      return (s.n == 0) ? 1 : s.n * P + B + L + 1;
   endfunction

   function automatic exp_t model(input scn_t s, input int c);
      exp_t x;
      int   t1, ls, le, dn, rs, e;
      bit   alive, rep_on, cap;
      t1     = s.n * P;
      ls     = t1 + B + 1;
      le     = t1 + B + L;
      dn     = done_of(s);
      rs     = dn + R + 1;
      alive  = (s.ab < 0) || (c <= s.ab);
      rep_on = REP && s.n != 0 && c >= rs && (s.ab < 0 || s.ab >= rs);
      e      = -1;
      if (s.n != 0)
         for (int j = ls; j <= le; j++)
            if (e < 0 && echo_at(s, j)) e = j;
      cap    = (e >= 0) && (s.ab < 0 || e < s.ab) && c > e && !rep_on;
      x.tx   = alive && s.n != 0 &&
               ((c >= 1 && c <= t1) || (rep_on && c < rs + t1));
      x.pwm  = !x.tx;
      x.lis  = alive && s.n != 0 && c >= ls && c <= le;
      x.done = alive && c == dn;
      x.busy = alive && c >= 1 && (c <= dn || (REP && s.n != 0));
      x.val  = alive && cap;
      x.tof  = cap ? e - 1 : 0;
      x.ctof = (c >= 1);
      return x;
   endfunction

   task automatic compare(input int k, input int c, input exp_t x);
      string p;
      p = $sformatf("s%0d c%0d", k, c);
      chk({p, " tx_en"},   32'(bus.tx_en_out),   32'(x.tx));
      chk({p, " pwm_rst"}, 32'(bus.pwm_rst_out), 32'(x.pwm));
      chk({p, " listen"},  32'(bus.listen_out),  32'(x.lis));
      chk({p, " busy"},    32'(bus.busy_out),    32'(x.busy));
      chk({p, " done"},    32'(bus.done_out),    32'(x.done));
      if (x.ctof) begin
         chk({p, " tof_valid"}, 32'(bus.tof_valid_out), 32'(x.val));
         chk({p, " tof"},       32'(bus.tof_out),       32'(x.tof));
      end
   endtask

   task automatic run_scn(input int k, input scn_t s);
      int   len;
      exp_t x;
      len = (s.len > 0) ? s.len : done_of(s) + 5;
      for (int c = 0; c < len; c++) begin
         @(posedge clk);
         #1;
         bus.trigger_in    = (c == 0) || (c == s.tr2);
         bus.abort_in      = (c == s.ab);
         bus.num_pulses_in = PW'(s.n);
         bus.echo_in       = echo_at(s, c);
         sb.push_back(model(s, c));
         @(negedge clk);
         x = sb.pop_front();
         compare(k, c, x);
      end
      @(posedge clk);
      #1;
      bus.trigger_in = 1'b0;
      bus.abort_in   = 1'b0;
      bus.echo_in    = 1'b0;
   endtask

   task automatic cleanup();
      @(posedge clk);
      #1;
      bus.abort_in = 1'b1;
      @(posedge clk);
      #1;
      bus.abort_in = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic chk_reset_vals(input string p);
      chk({p, " pwm_rst"},   32'(bus.pwm_rst_out),   32'd1);
      chk({p, " tx_en"},     32'(bus.tx_en_out),     32'd0);
      chk({p, " listen"},    32'(bus.listen_out),    32'd0);
      chk({p, " busy"},      32'(bus.busy_out),      32'd0);
      chk({p, " done"},      32'(bus.done_out),      32'd0);
      chk({p, " tof"},       32'(bus.tof_out),       32'd0);
      chk({p, " tof_valid"}, 32'(bus.tof_valid_out), 32'd0);
   endtask

   initial begin
      scn_t s;
      bus.trigger_in    = 1'b0;
      bus.abort_in      = 1'b0;
      bus.num_pulses_in = '0;
      bus.echo_in       = 1'b0;

      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b0;
      repeat (2) @(posedge clk);

      //             n   lo   hi   e2   ab  tr2 len
      tbl.push_back('{3,  -1,  -1,  -1,  -1, -1, 0});
      tbl.push_back('{3,  80,  80, 120,  -1, -1, 0});
      tbl.push_back('{3,   1,  50,  -1,  -1, -1, 0});
      tbl.push_back('{0,  -1,  -1,  -1,  -1, -1, 0});
      tbl.push_back('{3,  -1,  -1,  -1,  15,  5, 0});
      tbl.push_back('{3,  -1,  -1,  -1,   0, -1, 0});
      tbl.push_back('{1,  31,  31,  -1,  -1, -1, 0});
      tbl.push_back('{2, 140, 140,  -1,  -1, -1, 0});
      tbl.push_back('{1,  40,  40,  -1,  60, -1, 0});
      tbl.push_back('{2,  -1,  -1,  -1,  20, -1, 0});
      tbl.push_back('{255, 2600, 2600, -1, -1, -1, 0});
`ifdef SONAR_AUTO_REPEAT_EN
      tbl.push_back('{3,  80,  80,  -1,  -1, -1, 200});
`endif

      foreach (tbl[k]) begin
         run_scn(k, tbl[k]);
         cleanup();
      end

      // async reset in the middle of RINGDOWN
      s = '{3, -1, -1, -1, -1, -1, 41};
      run_scn(100, s);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_vals("async_rst");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      run_scn(101, tbl[1]);
      cleanup();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
